// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, limits and rounding-mode encoding for the FP round/pack path
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 28;
    localparam int FRAC_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX        = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_MAX_FINITE = 8'hFE;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rm_e;

endpackage

// File: rtl/round_decide.sv
// rtl/round_decide.sv - combinational round-increment and inexact decision from LSB/G/R/S, sign and mode
module round_decide
    import fp_pkg::*;
(
    input  logic       lsb,
    input  logic       guard,
    input  logic       rnd,
    input  logic       sticky,
    input  logic       sign,
    input  logic [1:0] rm,
    output logic       increment,
    output logic       inexact
);

    logic any_grs;

    always_comb begin
        any_grs   = guard | rnd | sticky;
        inexact   = any_grs;
        increment = 1'b0;
        case (rm)
            RM_RNE:  increment = guard & (rnd | sticky | lsb);
            RM_RTZ:  increment = 1'b0;
            RM_RUP:  increment = ~sign & any_grs;
            RM_RDN:  increment = sign & any_grs;
            default: increment = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - two-stage round and pack of a normalized mantissa into an IEEE-754 single word.
// Optional FP_ROUND_MODES_EN adds the rm[1:0] port (RNE/RTZ/RUP/RDN); default build is RNE only.
module fp_round_pack
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mantis_in,
`ifdef FP_ROUND_MODES_EN
    input  logic [1:0]        rm,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              flag_inexact,
    output logic              flag_overflow
);

    logic s1_adv;
    logic s2_adv;

    logic [1:0]  rm_in;
    logic        lsb;
    logic        guard;
    logic        rnd;
    logic        sticky;
    logic        passthru_in;
    logic        inc_raw;
    logic        inexact_raw;
    logic        increment;
    logic [24:0] rounded_in;

    logic             s1_valid_q,    s1_valid_d;
    logic             s1_sign_q,     s1_sign_d;
    logic [EXP_W-1:0] s1_exp_q,      s1_exp_d;
    logic [24:0]      s1_rounded_q,  s1_rounded_d;
    logic             s1_inexact_q,  s1_inexact_d;
    logic             s1_passthru_q, s1_passthru_d;
`ifdef FP_ROUND_MODES_EN
    logic [1:0]       s1_rm_q,       s1_rm_d;
`endif

    logic              saturate;
    logic [EXP_W:0]    exp_final;
    logic [FRAC_W-1:0] frac_final;
    logic [31:0]       pack_result;
    logic              pack_inexact;
    logic              pack_overflow;

    logic        s2_valid_q,      s2_valid_d;
    logic [31:0] result_q,        result_d;
    logic        flag_inexact_q,  flag_inexact_d;
    logic        flag_overflow_q, flag_overflow_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

`ifdef FP_ROUND_MODES_EN
    assign rm_in = rm;
`else
    assign rm_in = RM_RNE;
`endif

    round_decide u_round_decide (
        .lsb       (lsb),
        .guard     (guard),
        .rnd       (rnd),
        .sticky    (sticky),
        .sign      (sign_in),
        .rm        (rm_in),
        .increment (inc_raw),
        .inexact   (inexact_raw)
    );

    // Inf/NaN operands bypass rounding, so the increment is suppressed for them.
    always_comb begin
        lsb         = mantis_in[4];
        guard       = mantis_in[3];
        rnd         = mantis_in[2];
        sticky      = |mantis_in[1:0];
        passthru_in = (exp_in == EXP_MAX);
        increment   = inc_raw & ~passthru_in;
        rounded_in  = {1'b0, mantis_in[27:4]} + {24'd0, increment};
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_sign_d     = s1_sign_q;
        s1_exp_d      = s1_exp_q;
        s1_rounded_d  = s1_rounded_q;
        s1_inexact_d  = s1_inexact_q;
        s1_passthru_d = s1_passthru_q;
`ifdef FP_ROUND_MODES_EN
        s1_rm_d       = s1_rm_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d     = sign_in;
                s1_exp_d      = exp_in;
                s1_rounded_d  = rounded_in;
                s1_inexact_d  = inexact_raw;
                s1_passthru_d = passthru_in;
`ifdef FP_ROUND_MODES_EN
                s1_rm_d       = rm_in;
`endif
            end
        end
    end

    // Directed modes saturate when overflowing away from their favoured direction.
`ifdef FP_ROUND_MODES_EN
    assign saturate = (s1_rm_q == RM_RTZ)
                    | ((s1_rm_q == RM_RUP) & s1_sign_q)
                    | ((s1_rm_q == RM_RDN) & ~s1_sign_q);
`else
    assign saturate = 1'b0;
`endif

    always_comb begin
        exp_final  = {1'b0, s1_exp_q};
        frac_final = s1_rounded_q[22:0];
        if (s1_rounded_q[24]) begin
            exp_final  = {1'b0, s1_exp_q} + 9'd1;
            frac_final = '0;
        end else if (s1_exp_q == '0) begin
            exp_final = {8'd0, s1_rounded_q[23]};
        end

        pack_result   = {s1_sign_q, exp_final[7:0], frac_final};
        pack_inexact  = s1_inexact_q;
        pack_overflow = 1'b0;
        if (s1_passthru_q) begin
            pack_result  = {s1_sign_q, EXP_MAX, s1_rounded_q[22:0]};
            pack_inexact = 1'b0;
        end else if (exp_final >= 9'd255) begin
            pack_overflow = 1'b1;
            pack_inexact  = 1'b1;
            pack_result   = saturate ? {s1_sign_q, EXP_MAX_FINITE, {FRAC_W{1'b1}}}
                                     : {s1_sign_q, EXP_MAX, {FRAC_W{1'b0}}};
        end
    end

    always_comb begin
        s2_valid_d      = s2_valid_q;
        result_d        = result_q;
        flag_inexact_d  = flag_inexact_q;
        flag_overflow_d = flag_overflow_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d        = pack_result;
                flag_inexact_d  = pack_inexact;
                flag_overflow_d = pack_overflow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_sign_q       <= 1'b0;
            s1_exp_q        <= '0;
            s1_rounded_q    <= '0;
            s1_inexact_q    <= 1'b0;
            s1_passthru_q   <= 1'b0;
`ifdef FP_ROUND_MODES_EN
            s1_rm_q         <= '0;
`endif
            s2_valid_q      <= 1'b0;
            result_q        <= '0;
            flag_inexact_q  <= 1'b0;
            flag_overflow_q <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_sign_q       <= s1_sign_d;
            s1_exp_q        <= s1_exp_d;
            s1_rounded_q    <= s1_rounded_d;
            s1_inexact_q    <= s1_inexact_d;
            s1_passthru_q   <= s1_passthru_d;
`ifdef FP_ROUND_MODES_EN
            s1_rm_q         <= s1_rm_d;
`endif
            s2_valid_q      <= s2_valid_d;
            result_q        <= result_d;
            flag_inexact_q  <= flag_inexact_d;
            flag_overflow_q <= flag_overflow_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign result        = result_q;
    assign flag_inexact  = flag_inexact_q;
    assign flag_overflow = flag_overflow_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// tb/tb_fp_round_pack.sv - directed self-checking bench for fp_round_pack
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = 8'd0;
    logic [27:0] mantis_in = 28'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_inexact;
    logic        flag_overflow;
`ifdef FP_ROUND_MODES_EN
    logic [1:0]  rm = 2'b00;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_idx = 0;
    logic [33:0] exp_q[$];

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic [31:0] r;
        logic        inx;
        logic        ovf;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_round_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sign_in       (sign_in),
        .exp_in        (exp_in),
        .mantis_in     (mantis_in),
`ifdef FP_ROUND_MODES_EN
        .rm            (rm),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .flag_inexact  (flag_inexact),
        .flag_overflow (flag_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m,
                        input logic push, input logic [31:0] r, input logic inx, input logic ovf);
        int waited;
        waited = 0;
        sign_in   = s;
        exp_in    = e;
        mantis_in = m;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        if (push) exp_q.push_back({r, inx, ovf});
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("out%0d_result", out_idx), result, e[33:2]);
                check($sformatf("out%0d_inexact", out_idx), 32'(flag_inexact), 32'(e[1]));
                check($sformatf("out%0d_overflow", out_idx), 32'(flag_overflow), 32'(e[0]));
                out_idx++;
            end
        end
    end

    initial begin
        #200000;
        check("global_timeout", 32'd1, 32'(rst_n & 1'b0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int c0;
        vecs.push_back({1'b0, 8'h7F, 28'h8000018, 32'h3F800002, 1'b1, 1'b0});
        vecs.push_back({1'b0, 8'h7F, 28'h8000008, 32'h3F800000, 1'b1, 1'b0});
        vecs.push_back({1'b0, 8'h7F, 28'hFFFFFF8, 32'h40000000, 1'b1, 1'b0});
        vecs.push_back({1'b0, 8'hFE, 28'hFFFFFF8, 32'h7F800000, 1'b1, 1'b1});
        vecs.push_back({1'b0, 8'h00, 28'h7FFFFF8, 32'h00800000, 1'b1, 1'b0});
        vecs.push_back({1'b0, 8'hFF, 28'h8400008, 32'h7F840000, 1'b0, 1'b0});
        vecs.push_back({1'b1, 8'h80, 28'hC000004, 32'hC0400000, 1'b1, 1'b0});
        vecs.push_back({1'b0, 8'h7F, 28'h8000009, 32'h3F800001, 1'b1, 1'b0});
        vecs.push_back({1'b0, 8'h00, 28'h0000010, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back({1'b1, 8'hFE, 28'hFFFFFF8, 32'hFF800000, 1'b1, 1'b1});
        vecs.push_back({1'b0, 8'h7F, 28'h8000014, 32'h3F800001, 1'b1, 1'b0});

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_inexact", 32'(flag_inexact), 32'd0);
        check("rst_overflow", 32'(flag_overflow), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        send(1'b0, 8'h7F, 28'h8000000, 1'b1, 32'h3F800000, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2", 32'(out_valid), 32'd1);
        drain();

        @(posedge clk);
        #1;
        c0 = cyc;
        foreach (vecs[i]) send(vecs[i].s, vecs[i].e, vecs[i].m, 1'b1, vecs[i].r, vecs[i].inx, vecs[i].ovf);
        in_valid = 1'b0;
        check("throughput_cycles", 32'(cyc - c0), 32'(vecs.size()));
        drain();

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(1'b0, 8'h7F, 28'h8000018, 1'b1, 32'h3F800002, 1'b1, 1'b0);
                send(1'b0, 8'h7F, 28'h8000000, 1'b1, 32'h3F800000, 1'b0, 1'b0);
                send(1'b1, 8'h80, 28'hC000004, 1'b1, 32'hC0400000, 1'b1, 1'b0);
                in_valid = 1'b0;
            end
            begin
                @(negedge clk);
                @(negedge clk);
                repeat (2) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_result_hold", result, 32'h3F800002);
                    check("stall_inexact_hold", 32'(flag_inexact), 32'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(1'b0, 8'h7F, 28'h8000018, 1'b0, 32'h0, 1'b0, 1'b0);
        send(1'b0, 8'hFE, 28'hFFFFFF8, 1'b0, 32'h0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_inexact", 32'(flag_inexact), 32'd0);
        check("midrst_overflow", 32'(flag_overflow), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(1'b1, 8'h7F, 28'h8000000, 1'b1, 32'hBF800000, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("postrst_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("postrst_lat2", 32'(out_valid), 32'd1);
        drain();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
